// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared FSM states, ID constants and destination decode for the packet bus controller.
package bus_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;
  localparam int ID_W = 8;
  localparam int PKT_MAX = 256;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  // Packets are zero-extended to PKT_MAX bits; w is the real packet width.
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX-1:0] p, input int w);
    return p[w-1 -: ID_W];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search for the first request at or above rr_ptr, with wrap-around.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);
  always_comb begin
    int t;
    t = 0;
    gnt_idx = '0;
    gnt_valid = 1'b0;
    // Walk from the farthest offset down so the closest request to rr_ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      t = int'(rr_ptr) + k;
      t = t >= N ? t - N : t;
      if (req[t]) begin
        gnt_idx = ($clog2(N))'(t);
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_port_ctrl.sv
// bus_port_ctrl: round-robin pop of one device packet, then push to its destination(s) or broadcast.
// Optional BUS_DROP_CNT_EN adds a saturating drop_cnt output counting dropped packets.
module bus_port_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter logic [ID_W-1:0] bcast_id = BCAST_ID
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic                       busy
`ifdef BUS_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);
  localparam int PW = $clog2(drvrs);
  state_t state_q, state_d;
  logic [PW-1:0] src_q, src_d, rr_q, rr_d, gnt_idx;
  logic gnt_valid, busy_q, busy_d;
  logic [drvrs-1:0] pop_q, pop_d, push_q, push_d;
  logic [pckg_sz-1:0] pkt_q, pkt_d, cur;
  logic [ID_W-1:0] dest;
  rr_arbiter #(.N(drvrs)) u_arb (
    .req(pndng),
    .rr_ptr(rr_q),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid)
  );
  assign cur = D_pop[src_q*pckg_sz +: pckg_sz];
  assign dest = dest_of(PKT_MAX'(cur), pckg_sz);
  // Push is decoded straight from D_pop in GRANT so it can be registered for the DELIVER cycle.
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    rr_d = rr_q;
    pkt_d = pkt_q;
    pop_d = '0;
    push_d = '0;
    case (state_q)
      IDLE: if (gnt_valid) begin
        state_d = GRANT;
        src_d = gnt_idx;
        pop_d = drvrs'(1) << gnt_idx;
      end
      GRANT: begin
        state_d = DELIVER;
        pkt_d = cur;
        rr_d = src_q == PW'(drvrs - 1) ? '0 : src_q + 1'b1;
        push_d = dest == bcast_id ? ~(drvrs'(1) << src_q) :
                 (int'(dest) < drvrs && int'(dest) != int'(src_q)) ? drvrs'(1) << dest : '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q <= '0;
      rr_q <= '0;
      pkt_q <= '0;
      pop_q <= '0;
      push_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      rr_q <= rr_d;
      pkt_q <= pkt_d;
      pop_q <= pop_d;
      push_q <= push_d;
      busy_q <= busy_d;
    end
  end
  assign pop = pop_q;
  assign push = push_q;
  assign D_push = pkt_q;
  assign busy = busy_q;
`ifdef BUS_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else if (state_q == DELIVER && push_q == '0 && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_bus_port_ctrl.sv
// tb_bus_port_ctrl: directed vector table plus round-robin, reset and idle sequences for bus_port_ctrl.
module tb_bus_port_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] pndng = '0;
  logic [63:0] D_pop = '0;
  logic [3:0] pop, push;
  logic [15:0] D_push;
  logic busy;
  int checks = 0;
  int failures = 0;
`ifdef BUS_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  bus_port_ctrl #(.drvrs(4), .pckg_sz(16)) dut (
    .clk(clk),
    .reset(reset),
    .pndng(pndng),
    .D_pop(D_pop),
    .pop(pop),
    .push(push),
    .D_push(D_push),
    .busy(busy)
`ifdef BUS_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  pn;
    logic [63:0] d;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] dp;
  } vec_t;
  vec_t vec [9];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    logic [3:0] ep;
    vec[0] = '{4'b0001, 64'h0000_0000_0000_02AB, 4'b0001, 4'b0100, 16'h02AB};
    vec[1] = '{4'b0010, 64'h0000_0000_FF5A_0000, 4'b0010, 4'b1101, 16'hFF5A};
    vec[2] = '{4'b1000, 64'h0711_0000_0000_0000, 4'b1000, 4'b0000, 16'h0711};
    vec[3] = '{4'b1000, 64'h0322_0000_0000_0000, 4'b1000, 4'b0000, 16'h0322};
    vec[4] = '{4'b0101, 64'h0000_0102_0000_0301, 4'b0001, 4'b1000, 16'h0301};
    vec[5] = '{4'b0101, 64'h0000_0102_0000_0301, 4'b0100, 4'b0010, 16'h0102};
    vec[6] = '{4'b1001, 64'h00CC_0000_0000_FF00, 4'b1000, 4'b0001, 16'h00CC};
    vec[7] = '{4'b0100, 64'h0000_FF77_0000_0000, 4'b0100, 4'b1011, 16'hFF77};
    vec[8] = '{4'b0010, 64'h0000_0000_0133_0000, 4'b0010, 4'b0000, 16'h0133};
    #1;
    chk("reset_outputs", {28'h0, pop, push, D_push, 7'h0, busy}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pndng = vec[i].pn;
      D_pop = vec[i].d;
      @(negedge clk);
      chk($sformatf("v%0d_pop", i), {60'h0, pop}, {60'h0, vec[i].pop});
      chk($sformatf("v%0d_busy_grant", i), {63'h0, busy}, 64'h1);
      pndng = '0;
      @(negedge clk);
      chk($sformatf("v%0d_push", i), {56'h0, pop, push}, {60'h0, vec[i].push});
      if (vec[i].push != '0) chk($sformatf("v%0d_dpush", i), {48'h0, D_push}, {48'h0, vec[i].dp});
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {55'h0, pop, push, busy}, 64'h0);
    end
`ifdef BUS_DROP_CNT_EN
    chk("drop_cnt", {48'h0, drop_cnt}, 64'd3);
`endif
    pndng = 4'b0001;
    D_pop = 64'h0000_0000_0000_0155;
    @(negedge clk);
    chk("rst_grant_pop", {60'h0, pop}, 64'h1);
    #2 reset = 1'b1;
    #1 chk("rst_async_clear", {55'h0, pop, push, busy}, 64'h0);
    pndng = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_no_push", {56'h0, pop, push}, 64'h0);
    end
    pndng = 4'b1111;
    D_pop = 64'h0201_0100_0003_0002;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      ep = (c % 3 == 1) ? 4'b0001 << ((c / 3) % 4) : 4'b0000;
      chk($sformatf("rr_c%0d", c), {60'h0, pop}, {60'h0, ep});
    end
    pndng = '0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_stable", {55'h0, pop, push, busy}, 64'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
